// File: rtl/fir_pkg.sv
// fir_pkg: shared widths and the round/saturate helper used by the FIR
// output decimator.
//   FIR_IN_W  - FIR input sample width
//   FIR_OUT_W - FIR output (output_y) width, decimator input width
//   DEC_OUT_W - decimator output width
//   round_sat - round-half-up arithmetic right shift followed by
//               saturation to a signed out_w-bit range
package fir_pkg;

    localparam int FIR_IN_W  = 19;
    localparam int FIR_OUT_W = 20;
    localparam int DEC_OUT_W = 16;

    // Working width for round_sat; wide enough that the rounding offset can
    // never overflow for any supported input width.
    localparam int RS_W = 40;

    // Returns the rounded, saturated value sign-extended to RS_W bits; the
    // caller keeps the low out_w bits.
    function automatic logic signed [RS_W-1:0] round_sat(
        input logic signed [RS_W-1:0] value,
        input int unsigned            shift,
        input int unsigned            out_w
    );
        logic signed [RS_W-1:0] t;
        logic signed [RS_W-1:0] r;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        t  = value + (RS_W'(1) << (shift - 1));
        r  = t >>> shift;
        hi = (RS_W'(1) << (out_w - 1)) - RS_W'(1);
        lo = ~hi;
        if (r > hi) begin
            return hi;
        end else if (r < lo) begin
            return lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO with a registered head.
//   clk, rst   - clock, synchronous active-high reset
//   push       - write request (ignored when full unless popping this cycle)
//   push_data  - write data
//   pop        - read request (ignored when empty)
//   head       - current head entry; holds its last value when empty
//   count      - occupied entries (0..DEPTH), authoritative full/empty
//   full/empty - count==DEPTH / count==0
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_nxt;
    logic [CW-1:0] count_nxt;
    logic [W-1:0]  head_nxt;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // head is registered: it is computed from the post-edge pointer and
    // memory state, bypassing the write when the new entry becomes the head.
    always_comb begin
        rd_nxt    = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
        head_nxt = head;
        if (count_nxt != '0) begin
            if (do_push && (wr_ptr == rd_nxt)) begin
                head_nxt = push_data;
            end else begin
                head_nxt = mem[rd_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            count  <= count_nxt;
            head   <= head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fir_out_decim.sv
// fir_out_decim: decimates the FIR output stream, rounds/saturates the kept
// samples to OUT_W bits and buffers them for a valid/ready consumer.
//   clk, rst   - clock, synchronous active-high reset
//   in_valid   - FIR sample valid this cycle
//   in_y       - signed FIR output sample (IN_W bits)
//   out_valid  - FIFO head valid
//   out_ready  - consumer accepts head when out_valid & out_ready
//   out_data   - signed FIFO head (OUT_W bits)
//   fifo_count - occupied FIFO entries
//   overflow   - sticky: a decimated sample was dropped on a full FIFO
// Build option FIR_DECIM_AVG_EN: average each group of DECIM valid samples
// instead of picking the first sample of the group.
module fir_out_decim
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_OUT_W,
    parameter int OUT_W = DEC_OUT_W,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [IN_W-1:0]        in_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    localparam int SHIFT = IN_W - OUT_W;
    localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

    logic [PH_W-1:0]         phase;
    logic                    keep;
    logic signed [RS_W-1:0]  sel_wide;
    logic signed [RS_W-1:0]  rounded;
    logic [RS_W-1:OUT_W]     unused_round_hi;
    logic                    push_en;
    logic [OUT_W-1:0]        push_data;
    logic                    pop;
    logic                    full;
    logic                    empty;

    // Phase advances only on valid beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (in_valid) begin
            phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
        end
    end

`ifdef FIR_DECIM_AVG_EN
    localparam int LOG2D = $clog2(DECIM);
    localparam int ACC_W = IN_W + LOG2D;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;

    // Sum includes the current sample, so the group's last beat sees the
    // complete total without waiting a cycle.
    always_comb begin
        sum      = acc + ACC_W'($signed(in_y));
        keep     = in_valid && (phase == PH_LAST);
        sel_wide = RS_W'(sum >>> LOG2D);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (in_valid) begin
            acc <= (phase == PH_LAST) ? '0 : sum;
        end
    end
`else
    always_comb begin
        keep     = in_valid && (phase == '0);
        sel_wide = RS_W'($signed(in_y));
    end
`endif

    always_comb begin
        rounded         = round_sat(sel_wide, SHIFT, OUT_W);
        unused_round_hi = rounded[RS_W-1:OUT_W];
    end

    // Stage 1: register the rounded kept sample before the FIFO write.
    always_ff @(posedge clk) begin
        if (rst) begin
            push_en   <= 1'b0;
            push_data <= '0;
        end else begin
            push_en   <= keep;
            push_data <= rounded[OUT_W-1:0];
        end
    end

    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push_en && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_en),
        .push_data (push_data),
        .pop       (pop),
        .head      (out_data),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_fir_out_decim.sv
module tb_fir_out_decim;

    localparam int IN_W  = 20;
    localparam int OUT_W = 16;
    localparam int DECIM = 4;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int SHIFT = IN_W - OUT_W;
`ifdef FIR_DECIM_AVG_EN
    localparam int KB = DECIM - 1;
`else
    localparam int KB = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [IN_W-1:0]  in_y;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [CW-1:0]    fifo_count;
    logic             overflow;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    bit armed  = 1'b0;

    // Scoreboard / reference model state
    int sb[$];
    int m_phase = 0;
    bit m_pe    = 1'b0;
    int m_pv    = 0;
    bit m_ovf   = 1'b0;
    int m_acc   = 0;

    fir_out_decim #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .DECIM (DECIM),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_y       (in_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic int sx(logic [IN_W-1:0] y);
        return int'($signed(y));
    endfunction

    function automatic int exp_round(int v);
        int r;
        r = (v + (1 << (SHIFT - 1))) >>> SHIFT;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // Model: checks current DUT state, then advances to the state expected
    // after the coming posedge.
    always @(negedge clk) begin : monitor
        int  sz;
        bit  p;
        if (armed) begin
            checks++;
            if (out_valid !== (sb.size() > 0)) begin
                errors++;
                $display("FAIL mon_out_valid: got %b expected %b", out_valid, (sb.size() > 0));
            end
            checks++;
            if (fifo_count !== CW'(sb.size())) begin
                errors++;
                $display("FAIL mon_fifo_count: got %0d expected %0d", fifo_count, sb.size());
            end
            checks++;
            if (overflow !== m_ovf) begin
                errors++;
                $display("FAIL mon_overflow: got %b expected %b", overflow, m_ovf);
            end
            if (sb.size() > 0) begin
                checks++;
                if (out_data !== OUT_W'(sb[0])) begin
                    errors++;
                    $display("FAIL mon_out_data: got %0d expected %0d", $signed(out_data), sb[0]);
                end
            end
        end
        if (rst) begin
            sb.delete();
            m_phase = 0;
            m_pe    = 1'b0;
            m_pv    = 0;
            m_ovf   = 1'b0;
            m_acc   = 0;
            armed   = 1'b1;
        end else if (armed) begin
            sz = sb.size();
            p  = (sz > 0) && (out_ready === 1'b1);
            if (p) begin
                void'(sb.pop_front());
                pops++;
            end
            if (m_pe) begin
                if (sz < DEPTH || p) sb.push_back(m_pv);
                else m_ovf = 1'b1;
            end
            m_pe = 1'b0;
            if (in_valid) begin
`ifdef FIR_DECIM_AVG_EN
                m_acc += sx(in_y);
                if (m_phase == DECIM - 1) begin
                    m_pe  = 1'b1;
                    m_pv  = exp_round(m_acc >>> $clog2(DECIM));
                    m_acc = 0;
                end
`else
                if (m_phase == 0) begin
                    m_pe = 1'b1;
                    m_pv = exp_round(sx(in_y));
                end
`endif
                m_phase = (m_phase + 1) % DECIM;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int v);
        in_valid = 1'b1;
        in_y     = IN_W'(v);
        tick();
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        in_y     = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // One decimation group whose kept result is k in either build.
    task automatic send_group(int k);
        for (int b = 0; b < DECIM; b++) send(k * 16);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_y      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (fifo_count !== '0) begin errors++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        tick();
    endtask

    task automatic test_basic();
        int vals[8] = '{24, 0, 0, 0, 23, 0, 0, 0};
        int p0;
        p0 = pops;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(vals[i]);
`ifndef FIR_DECIM_AVG_EN
            if (i == 0) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got %b expected 0", out_valid); end
            end
            if (i == 1) begin
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_2clk: got %b expected 1", out_valid); end
                checks++;
                if (out_data !== 16'd2) begin errors++; $display("FAIL basic_first: got %0d expected 2", out_data); end
            end
`endif
            checks++;
            if (fifo_count > 1) begin errors++; $display("FAIL basic_count_le1: got %0d expected <=1", fifo_count); end
        end
        idle(3);
        checks++;
        if (pops - p0 != 2) begin errors++; $display("FAIL basic_pops: got %0d expected 2", pops - p0); end
    endtask

    task automatic test_round_sat();
        int vals[12] = '{524287, 0, 0, 0, -524288, 0, 0, 0, -24, 0, 0, 0};
        int p0;
        p0 = pops;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) send(vals[i]);
        idle(3);
        checks++;
        if (pops - p0 != 3) begin errors++; $display("FAIL round_pops: got %0d expected 3", pops - p0); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL round_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_push_pop_full();
        int p0;
        p0 = pops;
        out_ready = 1'b0;
        for (int k = 11; k <= 18; k++) send_group(k);
        idle(2);
        checks++;
        if (fifo_count !== CW'(8)) begin errors++; $display("FAIL ppf_fill: got %0d expected 8", fifo_count); end
        // Ready is raised for exactly the edge where the kept sample is written.
        for (int k = 19; k <= 22; k++) begin
            for (int b = 0; b <= DECIM; b++) begin
                out_ready = (b == KB + 1);
                if (b < DECIM) send(k * 16);
                else idle(1);
                if (b == KB + 1) begin
                    checks++;
                    if (fifo_count !== CW'(8)) begin errors++; $display("FAIL ppf_count: got %0d expected 8", fifo_count); end
                    checks++;
                    if (overflow !== 1'b0) begin errors++; $display("FAIL ppf_overflow: got %b expected 0", overflow); end
                end
            end
        end
        out_ready = 1'b1;
        idle(10);
        checks++;
        if (pops - p0 != 12) begin errors++; $display("FAIL ppf_pops: got %0d expected 12", pops - p0); end
        checks++;
        if (fifo_count !== '0) begin errors++; $display("FAIL ppf_drain: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_overflow();
        int p0;
        out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) send_group(k);
        idle(2);
        checks++;
        if (fifo_count !== CW'(8)) begin errors++; $display("FAIL ovf_count: got %0d expected 8", fifo_count); end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        p0 = pops;
        out_ready = 1'b1;
        idle(10);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        checks++;
        if (pops - p0 != 8) begin errors++; $display("FAIL ovf_drain: got %0d expected 8", pops - p0); end
    endtask

    task automatic test_toggle();
        int p0;
        int n;
        p0 = pops;
        n  = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                send((n + 1) * 16);
                n++;
            end else begin
                in_valid = 1'b0;
                in_y     = IN_W'(12345);
                tick();
            end
        end
        idle(3);
        checks++;
        if (pops - p0 != 2) begin errors++; $display("FAIL toggle_pops: got %0d expected 2", pops - p0); end
    endtask

    task automatic test_reset_mid();
        int p0;
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_group(k);
        idle(2);
        checks++;
        if (fifo_count !== CW'(5)) begin errors++; $display("FAIL rmid_fill: got %0d expected 5", fifo_count); end
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (fifo_count !== '0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", fifo_count); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow: got %b expected 0", overflow); end
        p0 = pops;
        send(32);
        send(0);
`ifndef FIR_DECIM_AVG_EN
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_kept_valid: got %b expected 1", out_valid); end
        checks++;
        if (out_data !== 16'd2) begin errors++; $display("FAIL rmid_kept_data: got %0d expected 2", out_data); end
`endif
        send(0);
        send(0);
        idle(3);
        checks++;
        if (pops - p0 != 1) begin errors++; $display("FAIL rmid_pops: got %0d expected 1", pops - p0); end
    endtask

`ifdef FIR_DECIM_AVG_EN
    task automatic test_avg();
        out_ready = 1'b1;
        send(16);
        send(32);
        send(48);
        send(64);
        idle(1);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL avg_valid: got %b expected 1", out_valid); end
        checks++;
        if (out_data !== 16'd3) begin errors++; $display("FAIL avg_data: got %0d expected 3", out_data); end
        idle(3);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_y      = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_round_sat();
        test_push_pop_full();
        test_overflow();
        test_toggle();
        test_reset_mid();
`ifdef FIR_DECIM_AVG_EN
        test_avg();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
